dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024, meaning the data-memory size in 32-bit words (power of two).
REQ-002 The module SHALL have parameter READ_LATENCY, default 2, meaning the cycles from load acceptance to mem_read_data_valid (legal 1..7).
REQ-003 The module SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  meaning the reset, asynchronous, active-low.
REQ-005 The module SHALL have port mem_read_req  input  1  meaning the core requests a load and holds it until mem_read_data_valid.
REQ-006 The module SHALL have port mem_write_req  input  1  meaning the core requests a store and holds it until mem_write_ready.
REQ-007 The module SHALL have port mem_addr  input  32  meaning the byte address (rs1+imm).
REQ-008 The module SHALL have port mem_funct3  input  3  meaning the access size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-009 The module SHALL have port mem_write_data  input  32  meaning the store data, right-aligned (rs2).
REQ-010 The module SHALL have port mem_read_data  output  32  meaning the load result, sign- or zero-extended.
REQ-011 The module SHALL have port mem_read_data_valid  output  1  meaning a one-cycle pulse: load complete, mem_read_data valid.
REQ-012 The module SHALL have port mem_write_ready  output  1  meaning a one-cycle pulse: the store commits at the end of this cycle.
REQ-013 The module SHALL have port mem_error  output  1  meaning a one-cycle pulse, coincident with valid/ready: misaligned access or illegal funct3.

Function
REQ-014 FSM states SHALL be IDLE, READ_WAIT, READ_DONE and WRITE.
REQ-015 IDLE with mem_write_req=1 SHALL go to WRITE; write has priority when both requests are high.
REQ-016 IDLE with only mem_read_req=1 SHALL issue the RAM read, load a counter with READ_LATENCY-1, and go to READ_WAIT (or READ_DONE if READ_LATENCY=1).
REQ-017 READ_WAIT SHALL decrement the counter each cycle and enter READ_DONE when it reaches 0, so valid rises exactly READ_LATENCY cycles after the accepting IDLE cycle.
REQ-018 READ_DONE SHALL assert mem_read_data_valid for one cycle, then return to IDLE; a new request is accepted the cycle after.
REQ-019 WRITE SHALL assert mem_write_ready for one cycle, update the addressed bytes at that edge, then return to IDLE.
REQ-020 Byte lanes for stores SHALL be: SB lane addr[1:0], SH lanes {addr[1],0}..+1, SW all four; untouched bytes SHALL be preserved.
REQ-021 Loads SHALL select the byte or halfword by addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-022 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-023 Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0) or funct3 in {011,110,111} SHALL complete the handshake normally with mem_error=1, no RAM write, and mem_read_data=0.
REQ-024 If the held request drops before completion, the FSM SHALL return to IDLE the next cycle with no RAM write and no pulse.
REQ-025 mem_read_data SHALL hold its last value outside READ_DONE; consumers SHALL sample it only with valid.

Reset
REQ-026 While rst_n=0, outputs SHALL be 0, the FSM SHALL be in IDLE, and the counter SHALL be 0, immediately and asynchronously.
REQ-027 Reset asserted mid-operation SHALL abort it with no RAM write; RAM contents SHALL NOT be reset.

Structure
REQ-028 Shared package SHALL hold the funct3 size constants, the FSM state enum, and the load/store opcode constants shared with the decoder.
REQ-029 RAM SHALL be a sub-module dmem_ram: single-port, synchronous read, 4-bit byte-enable write, DEPTH_WORDS deep.

Verification
REQ-030 SW 0xDEADBEEF @0x10, then LW @0x10 -> ready pulse 1 cycle after the req; valid exactly READ_LATENCY cycles after acceptance with data 0xDEADBEEF.
REQ-031 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-032 LW @0x12 -> valid with mem_error=1 and data 0; subsequent LW @0x10 is unchanged.
REQ-033 Read and write requests both high in IDLE -> write is serviced first; the read completes after the read is re-accepted in IDLE.
REQ-034 rst_n=0 in READ_WAIT -> outputs 0 immediately; no valid after release until a new request.
REQ-035 SW @(DEPTH_WORDS*4) -> aliases word 0; LW @0x0 returns the stored value.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared load/store constants, FSM states and lane helpers
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_READ_DONE,
        ST_WRITE
    } dmem_state_e;

    function automatic logic access_error(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: access_error = 1'b0;
            F3_H, F3_HU: access_error = off[0];
            F3_W:        access_error = |off;
            default:     access_error = 1'b1;
        endcase
    endfunction

    // Stores only look at the size bits; the unsigned encodings never reach a legal store.
    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_lanes = 4'b0001 << off;
            2'b01:   store_lanes = off[1] ? 4'b1100 : 4'b0011;
            default: store_lanes = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_align(input logic [31:0] data, input logic [1:0] off);
        store_align = data << {off, 3'b000};
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    load_extract = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   load_extract = {24'h0, sh[7:0]};
            F3_H:    load_extract = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   load_extract = {16'h0, sh[15:0]};
            F3_W:    load_extract = word;
            default: load_extract = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// rtl/dmem_responder_ram.sv - single-port synchronous-read RAM with byte enables
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: load/store handshake over a byte-lane RAM
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    input  logic [31:0] mem_addr,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_read_data_valid,
    output logic        mem_write_ready,
    output logic        mem_error
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

    dmem_state_e   state;
    logic [2:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [31:0]   rd_hold_q;

    logic [AW-1:0] req_idx;
    logic          accept_rd;
    logic          commit_wr;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [31:0]   load_word;
    logic          unused_addr_bits;

    assign req_idx          = mem_addr[AW+1:2];
    assign unused_addr_bits = ^mem_addr[31:AW+2];

    assign accept_rd = (state == ST_IDLE) && mem_read_req && !mem_write_req;
    assign commit_wr = (state == ST_WRITE) && mem_write_req;

    assign ram_en    = accept_rd || (commit_wr && !err_q);
    assign ram_we    = (commit_wr && !err_q) ? store_lanes(f3_q, off_q) : 4'b0000;
    assign ram_addr  = (state == ST_WRITE) ? idx_q : req_idx;
    assign ram_wdata = store_align(wdata_q, off_q);

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign load_word = err_q ? 32'h0 : load_extract(ram_rdata, f3_q, off_q);

    // Pulses are gated by the held request so a withdrawn request never completes.
    assign mem_read_data_valid = (state == ST_READ_DONE) && mem_read_req;
    assign mem_write_ready     = commit_wr;
    assign mem_error           = (mem_read_data_valid || mem_write_ready) && err_q;
    assign mem_read_data       = mem_read_data_valid ? load_word : rd_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            idx_q     <= '0;
            off_q     <= 2'd0;
            f3_q      <= 3'd0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            rd_hold_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_write_req || mem_read_req) begin
                        idx_q <= req_idx;
                        off_q <= mem_addr[1:0];
                        f3_q  <= mem_funct3;
                        err_q <= access_error(mem_funct3, mem_addr[1:0]);
                    end
                    if (mem_write_req) begin
                        wdata_q <= mem_write_data;
                        state   <= ST_WRITE;
                    end else if (mem_read_req) begin
                        cnt   <= LAT_M1;
                        state <= (READ_LATENCY == 1) ? ST_READ_DONE : ST_READ_WAIT;
                    end
                end
                ST_READ_WAIT: begin
                    if (!mem_read_req) begin
                        cnt   <= 3'd0;
                        state <= ST_IDLE;
                    end else if (cnt <= 3'd1) begin
                        cnt   <= 3'd0;
                        state <= ST_READ_DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_READ_DONE: begin
                    if (mem_read_req) begin
                        rd_hold_q <= load_word;
                    end
                    state <= ST_IDLE;
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder against a byte-array model
module tb_dmem_responder;

    localparam int DEPTH  = 64;
    localparam int LAT    = 3;
    localparam int NBYTES = DEPTH * 4;
    localparam int BUDGET = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rreq = 1'b0;
    logic        wreq = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        wready;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_mem [NBYTES];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mem_read_req        (rreq),
        .mem_write_req       (wreq),
        .mem_addr            (addr),
        .mem_funct3          (f3),
        .mem_write_data      (wdata),
        .mem_read_data       (rdata),
        .mem_read_data_valid (rvalid),
        .mem_write_ready     (wready),
        .mem_error           (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f);
        int s;
        s = int'(f) % 4;
        return (s == 0) ? 1 : (s == 1) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic [2:0] f, input logic [31:0] a);
        if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
        return (a % access_size(f)) != 0;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        int base;
        if (model_err(f, a)) return;
        base = int'(a % NBYTES);
        for (int i = 0; i < access_size(f); i++) model_mem[base + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
        logic [31:0] v;
        int base;
        if (model_err(f, a)) return 32'h0;
        base = int'(a % NBYTES);
        v = 32'h0;
        for (int i = 0; i < access_size(f); i++) v = v | (32'(model_mem[base + i]) << (8 * i));
        if (f == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
                            output int lat, output logic e);
        bit got;
        addr = a; f3 = f; wdata = d; wreq = 1'b1;
        lat = 0; got = 1'b0; e = 1'b0;
        while (!got && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
            if (wready) begin got = 1'b1; e = err; end
        end
        @(posedge clk); #1;
        wreq = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f,
                           output int lat, output logic [31:0] d, output logic e);
        bit got;
        addr = a; f3 = f; rreq = 1'b1;
        lat = 0; got = 1'b0; d = 32'h0; e = 1'b0;
        while (!got && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
            if (rvalid) begin got = 1'b1; d = rdata; e = err; end
        end
        @(posedge clk); #1;
        rreq = 1'b0;
    endtask

    task automatic store_chk(input string tag, input logic [31:0] a, input logic [2:0] f,
                             input logic [31:0] d);
        int lat;
        logic e;
        do_store(a, f, d, lat, e);
        check({tag, "_wlat"}, lat, 1);
        check({tag, "_werr"}, 32'(e), 32'(model_err(f, a)));
        model_store(a, f, d);
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a, input logic [2:0] f);
        int lat;
        logic [31:0] d;
        logic e;
        do_load(a, f, lat, d, e);
        check({tag, "_rlat"}, lat, LAT);
        check({tag, "_rdata"}, d, model_load(a, f));
        check({tag, "_rerr"}, 32'(e), 32'(model_err(f, a)));
    endtask

    task automatic load_const(input string tag, input logic [31:0] a, input logic [2:0] f,
                              input logic [31:0] exp_d, input logic exp_e);
        int lat;
        logic [31:0] d;
        logic e;
        do_load(a, f, lat, d, e);
        check({tag, "_rlat"}, lat, LAT);
        check({tag, "_rdata"}, d, exp_d);
        check({tag, "_rerr"}, 32'(e), 32'(exp_e));
    endtask

    initial begin
        int lat;
        int nvalid;
        logic [31:0] a;
        logic [2:0] f;
        logic [2:0] st_f3 [6];

        st_f3[0] = 3'd0; st_f3[1] = 3'd1; st_f3[2] = 3'd2;
        st_f3[3] = 3'd3; st_f3[4] = 3'd6; st_f3[5] = 3'd7;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_valid", 32'(rvalid), 32'h0);
        check("rst_ready", 32'(wready), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int w = 0; w < DEPTH; w++) store_chk("init", 32'(w * 4), 3'd2, $urandom);

        store_chk("sw_dead", 32'h10, 3'd2, 32'hDEAD_BEEF);
        load_const("lw_dead", 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0);

        store_chk("sb_80", 32'h13, 3'd0, 32'h0000_0080);
        load_const("lb_13", 32'h13, 3'd0, 32'hFFFF_FF80, 1'b0);
        load_const("lbu_13", 32'h13, 3'd4, 32'h0000_0080, 1'b0);
        load_const("lw_10", 32'h10, 3'd2, 32'h80AD_BEEF, 1'b0);
        check("hold_rdata", rdata, 32'h80AD_BEEF);

        load_const("lw_mis", 32'h12, 3'd2, 32'h0, 1'b1);
        load_const("lw_after_mis", 32'h10, 3'd2, 32'h80AD_BEEF, 1'b0);

        // Both requests together: write goes first, read follows once re-accepted.
        addr = 32'h20; f3 = 3'd2; wdata = 32'h1234_5678; wreq = 1'b1; rreq = 1'b1;
        @(posedge clk); #1;
        check("prio_ready", 32'(wready), 32'h1);
        check("prio_no_valid", 32'(rvalid), 32'h0);
        model_store(32'h20, 3'd2, 32'h1234_5678);
        @(posedge clk); #1;
        wreq = 1'b0;
        lat = 0;
        while (!rvalid && lat < BUDGET) begin @(posedge clk); #1; lat++; end
        check("prio_rlat", lat, LAT);
        check("prio_rdata", rdata, 32'h1234_5678);
        @(posedge clk); #1;
        rreq = 1'b0;

        // Reset while the load is still waiting on the RAM.
        addr = 32'h10; f3 = 3'd2; rreq = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_valid", 32'(rvalid), 32'h0);
        rreq = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nvalid = 0;
        repeat (LAT + 3) begin @(posedge clk); #1; if (rvalid) nvalid++; end
        check("midrst_no_valid", nvalid, 0);
        load_chk("post_rst", 32'h10, 3'd2);

        // Write withdrawn inside WRITE must not touch the RAM.
        addr = 32'h30; f3 = 3'd2; wdata = 32'hCAFE_F00D; wreq = 1'b1;
        @(posedge clk); #1;
        wreq = 1'b0;
        #1;
        check("drop_ready", 32'(wready), 32'h0);
        @(posedge clk); #1;
        load_chk("drop_unchanged", 32'h30, 3'd2);

        store_chk("alias_sw", 32'(NBYTES), 3'd2, 32'h55AA_33CC);
        load_const("alias_lw", 32'h0, 3'd2, 32'h55AA_33CC, 1'b0);

        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 2 * NBYTES - 1));
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            if ($urandom_range(0, 1) == 1) begin
                f = st_f3[$urandom_range(0, 5)];
                store_chk("rnd_st", a, f, $urandom);
            end else begin
                f = 3'($urandom_range(0, 7));
                load_chk("rnd_ld", a, f);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
